muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    // Requester side: drives operands and the start strobe.
    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    // Unit side: consumes operands, reports progress and result.
    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring
// divider sharing one accumulator pair and one IDLE/CALC/FIN state machine.
// One bit is resolved per clock; divide-by-zero and signed overflow skip CALC.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CW-1:0]      r_count;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_hi;        // product high half / partial remainder
    logic [WIDTH-1:0]   r_lo;        // multiplier -> product low / dividend -> quotient
    logic               r_neg;       // final result must be negated
    logic               r_special;   // result fixed at acceptance, no iteration
    logic [WIDTH-1:0]   r_spec_val;
    logic [WIDTH-1:0]   r_result;
    logic               r_done;

    // Request decode, evaluated on the live inputs while IDLE.
    logic               w_accept;
    logic               w_is_div;
    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_neg;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [WIDTH-1:0]   w_spec_val;

    // One-iteration datapath.
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_mul_hi;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_hi_next;
    logic [WIDTH-1:0]   w_lo_next;

    // Sign-corrected final value.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fin;

    assign w_accept = (r_state == S_IDLE) && bus.start && !r_done;

    // Operand signedness, magnitudes, result sign and special-case detection.
    always_comb begin
        w_is_div   = bus.op[2];
        w_a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                     (bus.op == OP_DIV)  || (bus.op == OP_REM);
        w_b_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
        w_a_neg    = w_a_signed && bus.a[WIDTH-1];
        w_b_neg    = w_b_signed && bus.b[WIDTH-1];
        w_a_mag    = w_a_neg ? (~bus.a + 1'b1) : bus.a;
        w_b_mag    = w_b_neg ? (~bus.b + 1'b1) : bus.b;
        // Remainder follows the dividend; products and quotients follow the xor.
        w_neg      = (w_is_div && bus.op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div_zero = w_is_div && (bus.b == '0);
        w_div_ovf  = w_is_div && !bus.op[0] && (bus.b == '1) &&
                     (bus.a == {1'b1, {(WIDTH-1){1'b0}}});
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        w_spec_val = '0;
        if (w_div_zero) begin
            w_spec_val = bus.op[1] ? bus.a : '1;
        end else if (w_div_ovf) begin
            w_spec_val = bus.op[1] ? '0 : bus.a;
        end
    end

    // One shift-add or one restoring-subtract step on the accumulator pair.
    always_comb begin
        w_sum    = {1'b0, r_hi} + {1'b0, r_opnd};
        w_mul_hi = r_lo[0] ? w_sum : {1'b0, r_hi};
        w_rem_sh = {r_hi, r_lo[WIDTH-1]};
        w_trial  = w_rem_sh - {1'b0, r_opnd};
        if (r_op[2]) begin
            w_hi_next = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
            w_lo_next = {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};
        end else begin
            w_hi_next = w_mul_hi[WIDTH:1];
            w_lo_next = {w_mul_hi[0], r_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and selection of the half/quantity the op returns.
    always_comb begin
        w_prod = r_neg ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
        w_quo  = r_neg ? (~r_lo + 1'b1) : r_lo;
        w_rem  = r_neg ? (~r_hi + 1'b1) : r_hi;
        if (r_special) begin
            w_fin = r_spec_val;
        end else if (r_op[2]) begin
            w_fin = r_op[1] ? w_rem : w_quo;
        end else if (r_op == OP_MUL) begin
            w_fin = w_prod[WIDTH-1:0];
        end else begin
            w_fin = w_prod[2*WIDTH-1:WIDTH];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    // Next-state logic: special cases bypass CALC, FIN always lasts one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_div_zero || w_div_ovf) ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == '0) begin
                    w_next_state = S_FIN;
                end
            end
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand capture, per-bit iteration and result/done registration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the whole datapath is cleared by reset, so an aborted operation leaves nothing behind.
            r_count    <= '0;
            r_op       <= '0;
            r_opnd     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_neg      <= 1'b0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= bus.op;
                        r_count    <= CW'(WIDTH - 1);
                        r_hi       <= '0;
                        r_opnd     <= w_is_div ? w_b_mag : w_a_mag;
                        r_lo       <= w_is_div ? w_a_mag : w_b_mag;
                        r_neg      <= w_neg;
                        r_special  <= w_div_zero || w_div_ovf;
                        r_spec_val <= w_spec_val;
                    end
                end
                S_CALC: begin
                    r_hi    <= w_hi_next;
                    r_lo    <= w_lo_next;
                    r_count <= r_count - 1'b1;
                end
                S_FIN: begin
                    r_result <= w_fin;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Busy covers the whole outstanding window, including the done cycle.
    assign bus.busy   = (r_state != S_IDLE) || r_done;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes expected result and
// latency on each accepted request, a monitor pops and checks on every done.
module tb_muldiv_unit;
    localparam int W = 32;

    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;

    typedef struct {
        logic [W-1:0] res;
        int           acc;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_done = 1'b0;
    exp_t sb_q[$];

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the RV32M definitions, using 64-bit arithmetic.
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        logic [63:0]     p;
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MUL:    begin p = ua * ub;            return p[31:0];  end
            MULH:   begin p = sa * sb;            return p[63:32]; end
            MULHSU: begin p = sa * longint'(ub);  return p[63:32]; end
            MULHU:  begin p = ua * ub;            return p[63:32]; end
            DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            DIVU:   begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            REM:    begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (op[2] && (b == 0)) return 1;
        if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Waits (bounded) until the unit is idle and not presenting done.
    task automatic wait_idle();
        int t = 0;
        while ((bus.busy || bus.done) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("idle_wait_timeout", 32'(t >= 100), 32'd0);
    endtask

    // Issues one request; expectations are recorded at the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input int exp_lat);
        wait_idle();
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        sb_q.push_back('{exp_res, cyc, exp_lat});
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic issue_rand(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(op, a, b, model(op, a, b), model_lat(op, a, b));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (bus.done) begin
                check("done_single_pulse", 32'(prev_done), 32'd0);
                check("done_has_pending", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("result", bus.result, e.res);
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
            prev_done = bus.done;
        end
    end

    initial begin
        int t;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed multiply cases.
        issue(MULH,   32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        issue(MULHU,  32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 33);
        issue(MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        issue(MUL,    32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33);

        // Directed divide cases, including division by zero and overflow.
        issue(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        issue(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        issue(DIVU, 32'd100, 32'd7, 32'd14, 33);
        issue(REMU, 32'd100, 32'd7, 32'd2, 33);
        issue(DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
        issue(REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Starts pulsed while busy must be dropped without queueing.
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd1; bus.b = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = MUL; bus.a = 32'd3; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;

        // Start held through done: next op accepted the cycle after done.
        wait_idle();
        bus.start = 1'b1; bus.op = MUL; bus.a = 32'd3; bus.b = 32'd5;
        @(posedge clk); #1;
        sb_q.push_back('{32'd15, cyc, 33});
        bus.op = DIVU; bus.a = 32'd100; bus.b = 32'd7;
        t = 0;
        while (!bus.done && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        check("held_done_timeout", 32'(t >= 60), 32'd0);
        @(posedge clk); #1;
        check("held_busy_gap", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        sb_q.push_back('{32'd14, cyc, 33});
        check("held_busy_resume", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;

        // Asynchronous reset in the middle of CALC, then a fresh multiply.
        issue(MUL, 32'd9, 32'd9, 32'd81, 33);
        repeat (9) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midop_reset_busy", 32'(bus.busy), 32'd0);
        check("midop_reset_done", 32'(bus.done), 32'd0);
        check("midop_reset_result", bus.result, 32'd0);
        sb_q.delete();
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        issue(MUL, 32'd7, 32'd6, 32'd42, 33);

        // Random regression across all eight operations.
        for (int i = 0; i < 2000; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue_rand(op, a, b);
        end

        // Drain outstanding work, then watch for any stray done.
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_timeout", 32'(sb_q.size()), 32'd0);
        repeat (40) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
